// File: rtl/qdu_iter_pkg.sv
// Shared definitions for the iterative quotient/remainder unit: divctl encodings,
// FSM states and the iteration-counter width helper.
package qdu_iter_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } qdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIXUP,
    S_DONE
  } qdu_state_e;

  function automatic int qdu_cnt_width(input int xlen, input int bpc);
    return $clog2(xlen / bpc) + 1;
  endfunction

endpackage

// File: rtl/qdu_iter_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial
// remainder and keep the difference when it does not go negative.
module qdu_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         qbit
);

  logic [W:0] diff;

  assign diff    = rem_in - {1'b0, divisor};
  assign qbit    = ~diff[W];
  assign rem_out = qbit ? diff[W-1:0] : rem_in[W-1:0];

endmodule

// File: rtl/qdu_iter.sv
// Iterative RV M-extension divide/remainder unit with valid/ready on both sides.
// Optional QDU_RESULT_CACHE_EN keeps the last result so a matching DIV/REM pair finishes early.
module qdu_iter
  import qdu_iter_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      divctl,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);

  localparam int NITER = XLEN / BITS_PER_CYCLE;
  localparam int CW    = qdu_cnt_width(XLEN, BITS_PER_CYCLE);

  qdu_state_e state_q, state_d;

  logic [XLEN-1:0] a_q, b_q, quo_q, rem_q, div_q, res_q;
  logic [1:0]      ctl_q;
  logic            negq_q, negr_q;
  logic [CW-1:0]   cnt_q;

  logic            accept, b_zero, ovf, special, cache_hit;
  logic [XLEN-1:0] sp_q, sp_r, hit_res, fix_q, fix_r, a_abs, b_abs;
  logic            sgn_q;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res       = res_q;

  assign accept  = in_valid & in_ready & ~flush;
  assign b_zero  = (b == '0);
  assign ovf     = ~divctl[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
  assign special = b_zero | ovf;
  assign sp_q    = b_zero ? '1 : a;
  assign sp_r    = b_zero ? a : '0;

  assign sgn_q = ~ctl_q[0];
  assign a_abs = (sgn_q & a_q[XLEN-1]) ? -a_q : a_q;
  assign b_abs = (sgn_q & b_q[XLEN-1]) ? -b_q : b_q;
  assign fix_q = negq_q ? -quo_q : quo_q;
  assign fix_r = negr_q ? -rem_q : rem_q;

  // Step chain: quo_q holds the not-yet-consumed dividend bits, MSB first, and
  // fills with quotient bits from the bottom as they are retired.
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : stg
    logic [XLEN-1:0] r_i, q_i, r_o, q_o;
    logic            qb;
    if (g == 0) begin : g_first
      assign r_i = rem_q;
      assign q_i = quo_q;
    end else begin : g_next
      assign r_i = stg[g-1].r_o;
      assign q_i = stg[g-1].q_o;
    end
    qdu_step #(.W(XLEN)) u_step (
      .rem_in  ({r_i, q_i[XLEN-1]}),
      .divisor (div_q),
      .rem_out (r_o),
      .qbit    (qb)
    );
    assign q_o = {q_i[XLEN-2:0], qb};
  end

`ifdef QDU_RESULT_CACHE_EN
  logic            c_vld, c_u, c_wr, w_u;
  logic [XLEN-1:0] c_a, c_b, c_q, c_r, w_a, w_b, w_q, w_r;

  always_comb begin
    c_wr = 1'b0;
    w_a  = a;
    w_b  = b;
    w_u  = divctl[0];
    w_q  = sp_q;
    w_r  = sp_r;
    if (state_q == S_FIXUP) begin
      c_wr = ~flush;
      w_a  = a_q;
      w_b  = b_q;
      w_u  = ctl_q[0];
      w_q  = fix_q;
      w_r  = fix_r;
    end else if (accept & special) begin
      c_wr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld <= 1'b0;
      c_u   <= 1'b0;
      c_a   <= '0;
      c_b   <= '0;
      c_q   <= '0;
      c_r   <= '0;
    end else if (flush) begin
      c_vld <= 1'b0;
    end else if (c_wr) begin
      c_vld <= 1'b1;
      c_u   <= w_u;
      c_a   <= w_a;
      c_b   <= w_b;
      c_q   <= w_q;
      c_r   <= w_r;
    end
  end

  assign cache_hit = c_vld & (a == c_a) & (b == c_b) & (divctl[0] == c_u);
  assign hit_res   = divctl[1] ? c_r : c_q;
`else
  assign cache_hit = 1'b0;
  assign hit_res   = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (special | cache_hit) ? S_DONE : S_PREP;
      S_PREP:  state_d = S_ITER;
      S_ITER:  if (cnt_q == '0) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      ctl_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else if (!flush) begin
      case (state_q)
        S_IDLE: if (accept) begin
          a_q   <= a;
          b_q   <= b;
          ctl_q <= divctl;
          if (special)        res_q <= divctl[1] ? sp_r : sp_q;
          else if (cache_hit) res_q <= hit_res;
        end
        S_PREP: begin
          quo_q  <= a_abs;
          rem_q  <= '0;
          div_q  <= b_abs;
          negq_q <= sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          negr_q <= sgn_q & a_q[XLEN-1];
          cnt_q  <= CW'(NITER - 1);
        end
        S_ITER: begin
          rem_q <= stg[BITS_PER_CYCLE-1].r_o;
          quo_q <= stg[BITS_PER_CYCLE-1].q_o;
          cnt_q <= cnt_q - 1'b1;
        end
        S_FIXUP: res_q <= ctl_q[1] ? fix_r : fix_q;
        default: ;
      endcase
    end
  end

endmodule
